sub_shift_folded: RTL and testbench

SUB_SHIFT_FOLDED -- requirements
Module: sub_shift_folded

---
 rtl/aes_pkg.sv | 23 ++
 rtl/sbox.sv | 39 +++
 rtl/sub_shift_folded.sv | 86 ++++++++
 tb/tb_sub_shift_folded.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared FSM encoding, ShiftRows index maps and lane-count helpers.
package aes_pkg;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    function automatic int beats(input int num_sbox);
        return 16 / num_sbox;
    endfunction

    function automatic bit num_sbox_ok(input int num_sbox);
        return num_sbox == 1 || num_sbox == 2 || num_sbox == 4 || num_sbox == 8 || num_sbox == 16;
    endfunction

    // Byte index is {column, row}, so column arithmetic wraps mod 4 in two bits.
    function automatic logic [3:0] enc_src(input logic [3:0] i);
        return {2'(i[3:2] + i[1:0]), i[1:0]};
    endfunction

    function automatic logic [3:0] dec_src(input logic [3:0] i);
        return {2'(i[3:2] - i[1:0]), i[1:0]};
    endfunction

endpackage

// File: rtl/sbox.sv
// sbox: AES forward S-box on a, inverse S-box on b, selected by decrypt.
module sbox (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       decrypt,
    output logic [7:0] c
);
    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] t;
        p = '0;
        t = x;
        for (int i = 0; i < 8; i++) begin
            p = y[i] ? p ^ t : p;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the GF(2^8) inverse (0 maps to 0): build x^127, then square.
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] t;
        t = x;
        for (int i = 0; i < 6; i++) t = gmul(gmul(t, t), x);
        return gmul(t, t);
    endfunction

    logic [7:0] fwd;
    logic [7:0] inv_in;
    logic [7:0] inv;

    always_comb begin
        fwd    = ginv(a);
        fwd    = fwd ^ {fwd[6:0], fwd[7]} ^ {fwd[5:0], fwd[7:6]} ^ {fwd[4:0], fwd[7:5]} ^ {fwd[3:0], fwd[7:4]} ^ 8'h63;
        inv_in = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        inv    = ginv(inv_in);
        c      = decrypt ? inv : fwd;
    end
endmodule

// File: rtl/sub_shift_folded.sv
// sub_shift_folded: AES (Inv)SubBytes+(Inv)ShiftRows folded over BEATS cycles
// with NUM_SBOX S-box lanes and a valid/ready handshake on both sides.
module sub_shift_folded
    import aes_pkg::*;
#(
    parameter int NUM_SBOX = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_decrypt,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);
    localparam int BEATS = beats(NUM_SBOX);
    localparam int CW    = BEATS > 1 ? $clog2(BEATS) : 1;

    if (!num_sbox_ok(NUM_SBOX)) begin : g_bad_num_sbox
        $error("NUM_SBOX must be 1, 2, 4, 8 or 16");
    end

    state_e         state_q;
    logic [CW-1:0]  beat_q;
    logic [127:0]   data_q;
    logic           dec_q;
    logic [127:0]   out_q;
    logic [127:0]   out_d;
    logic [7:0]     src [16];
    logic [3:0]     idx [NUM_SBOX];
    logic [7:0]     res [NUM_SBOX];
    logic           accept;
    logic           last;

    always_comb begin
        for (int i = 0; i < 16; i++) src[i] = data_q[127-8*i -: 8];
    end

    for (genvar j = 0; j < NUM_SBOX; j++) begin : g_lane
        assign idx[j] = 4'(int'(beat_q) * NUM_SBOX + j);
        sbox u_sbox (
            .a       (src[enc_src(idx[j])]),
            .b       (src[dec_src(idx[j])]),
            .decrypt (dec_q),
            .c       (res[j])
        );
    end

    always_comb begin
        out_d = out_q;
        for (int j = 0; j < NUM_SBOX; j++) out_d[127-8*int'(idx[j]) -: 8] = res[j];
    end

    assign in_ready  = state_q == S_IDLE || (state_q == S_DONE && out_ready);
    assign accept    = in_valid && in_ready;
    assign last      = beat_q == CW'(BEATS - 1);
    assign out_valid = state_q == S_DONE;
    assign busy      = state_q == S_RUN;
    assign out_data  = out_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            data_q  <= '0;
            dec_q   <= 1'b0;
            out_q   <= '0;
        end else begin
            if (state_q == S_RUN) out_q <= out_d;
            if (accept) begin
                state_q <= S_RUN;
                beat_q  <= '0;
                data_q  <= in_data;
                dec_q   <= in_decrypt;
            end else if (state_q == S_RUN) begin
                beat_q  <= last ? beat_q : beat_q + 1'b1;
                state_q <= last ? S_DONE : S_RUN;
            end else if (state_q == S_DONE && out_ready) begin
                state_q <= S_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_sub_shift_folded.sv
// tb_sub_shift_folded: directed checks of the folded SubBytes/ShiftRows block.
module tb_sub_shift_folded;
    localparam logic [127:0] X   = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] Y   = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] Z63 = {16{8'h63}};
    localparam logic [127:0] Z52 = {16{8'h52}};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [127:0] in_data = '0;
    logic         in_decrypt = 1'b0;
    logic         out_ready = 1'b0;
    logic         in_ready;
    logic         out_valid;
    logic [127:0] out_data;
    logic         busy;
    logic         ovs [4];
    logic [127:0] ods [4];
    logic         irs [4];
    logic         bss [4];
    int           checks = 0;
    int           failures = 0;

    always #5 clk = ~clk;

    sub_shift_folded #(.NUM_SBOX(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_decrypt(in_decrypt), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );
    sub_shift_folded #(.NUM_SBOX(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(irs[0]), .in_data(in_data),
        .in_decrypt(in_decrypt), .out_valid(ovs[0]), .out_ready(out_ready), .out_data(ods[0]), .busy(bss[0])
    );
    sub_shift_folded #(.NUM_SBOX(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(irs[1]), .in_data(in_data),
        .in_decrypt(in_decrypt), .out_valid(ovs[1]), .out_ready(out_ready), .out_data(ods[1]), .busy(bss[1])
    );
    sub_shift_folded #(.NUM_SBOX(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(irs[2]), .in_data(in_data),
        .in_decrypt(in_decrypt), .out_valid(ovs[2]), .out_ready(out_ready), .out_data(ods[2]), .busy(bss[2])
    );
    sub_shift_folded #(.NUM_SBOX(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(irs[3]), .in_data(in_data),
        .in_decrypt(in_decrypt), .out_valid(ovs[3]), .out_ready(out_ready), .out_data(ods[3]), .busy(bss[3])
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Accepts one block on the next edge and returns the result with its latency (0 = timeout).
    task automatic run_block(input logic [127:0] d, input logic dec, output logic [127:0] res, output int lat);
        in_valid   = 1'b1;
        in_data    = d;
        in_decrypt = dec;
        tick;
        in_valid = 1'b0;
        in_data  = '0;
        lat      = 0;
        for (int e = 1; e <= 40; e++) begin
            tick;
            if (out_valid) begin
                lat = e;
                break;
            end
        end
        res       = out_data;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ctrl: out_valid=%b busy=%b in_ready=%b, want 0 0 1", out_valid, busy, in_ready);
        end
        checks++;
        if (out_data !== '0) begin
            failures++;
            $display("FAIL reset_data: got %h want 0", out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_encrypt;
        logic [127:0] r;
        int lat;
        run_block(X, 1'b0, r, lat);
        checks++;
        if (r !== Y) begin
            failures++;
            $display("FAIL encrypt_data: got %h want %h", r, Y);
        end
        checks++;
        if (lat !== 4) begin
            failures++;
            $display("FAIL encrypt_latency: got %0d want 4", lat);
        end
    endtask

    task automatic test_decrypt;
        logic [127:0] r;
        int lat;
        run_block(Y, 1'b1, r, lat);
        checks++;
        if (r !== X || lat !== 4) begin
            failures++;
            $display("FAIL decrypt_data: got %h lat %0d want %h lat 4", r, lat, X);
        end
        run_block('0, 1'b0, r, lat);
        checks++;
        if (r !== Z63) begin
            failures++;
            $display("FAIL zero_encrypt: got %h want %h", r, Z63);
        end
        run_block('0, 1'b1, r, lat);
        checks++;
        if (r !== Z52) begin
            failures++;
            $display("FAIL zero_decrypt: got %h want %h", r, Z52);
        end
    endtask

    task automatic test_sweep;
        int lat [4];
        int want [4];
        want = '{16, 8, 2, 1};
        lat  = '{0, 0, 0, 0};
        rst_n = 1'b0;
        tick;
        @(negedge clk);
        rst_n      = 1'b1;
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        in_data    = X;
        in_decrypt = 1'b0;
        tick;
        in_valid = 1'b0;
        in_data  = '0;
        for (int e = 1; e <= 20; e++) begin
            tick;
            for (int k = 0; k < 4; k++) if (ovs[k] && lat[k] == 0) lat[k] = e;
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (lat[k] !== want[k] || ods[k] !== Y) begin
                failures++;
                $display("FAIL sweep_%0d: got %h lat %0d want %h lat %0d", 16 / want[k], ods[k], lat[k], Y, want[k]);
            end
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [127:0] din [4];
        logic         dm [4];
        logic [127:0] exp [4];
        int lat;
        din = '{X, Y, '0, '0};
        dm  = '{1'b0, 1'b1, 1'b0, 1'b1};
        exp = '{Y, X, Z63, Z52};
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        in_data    = din[0];
        in_decrypt = dm[0];
        tick;
        for (int b = 0; b < 4; b++) begin
            if (b < 3) begin
                in_data    = din[b+1];
                in_decrypt = dm[b+1];
            end else begin
                in_valid = 1'b0;
            end
            lat = 0;
            for (int e = 1; e <= 40; e++) begin
                tick;
                if (out_valid) begin
                    lat = e;
                    break;
                end
            end
            checks++;
            if (out_data !== exp[b] || lat !== 4) begin
                failures++;
                $display("FAIL b2b_block%0d: got %h lat %0d want %h lat 4", b, out_data, lat, exp[b]);
            end
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ready%0d: in_ready=%b want 1", b, in_ready);
            end
            tick;
            checks++;
            if (busy !== (b < 3) || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL b2b_next%0d: busy=%b out_valid=%b want %b 0", b, busy, out_valid, b < 3);
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        int lat;
        in_valid   = 1'b1;
        in_data    = X;
        in_decrypt = 1'b0;
        tick;
        in_data    = Y;
        in_decrypt = 1'b1;
        lat = 0;
        for (int e = 1; e <= 40; e++) begin
            tick;
            if (out_valid) begin
                lat = e;
                break;
            end
        end
        checks++;
        if (lat !== 4) begin
            failures++;
            $display("FAIL bp_latency: got %0d want 4", lat);
        end
        for (int c = 0; c < 10; c++) begin
            tick;
            checks++;
            if (out_valid !== 1'b1 || out_data !== Y || in_ready !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold%0d: ov=%b data=%h in_ready=%b busy=%b want 1 %h 0 0", c, out_valid, out_data, in_ready, busy, Y);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_data !== Y) begin
            failures++;
            $display("FAIL bp_release: in_ready=%b data=%h want 1 %h", in_ready, out_data, Y);
        end
        tick;
        in_valid = 1'b0;
        lat = 0;
        for (int e = 1; e <= 40; e++) begin
            if (out_valid) begin
                lat = e;
                break;
            end
            tick;
        end
        checks++;
        if (out_data !== X || lat == 0) begin
            failures++;
            $display("FAIL bp_followup: got %h valid_seen=%0d want %h", out_data, lat, X);
        end
        tick;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run;
        logic [127:0] r;
        int lat;
        in_valid   = 1'b1;
        in_data    = X;
        in_decrypt = 1'b0;
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midrun_reset: ov=%b data=%h busy=%b in_ready=%b want 0 0 0 1", out_valid, out_data, busy, in_ready);
        end
        tick;
        @(negedge clk);
        rst_n = 1'b1;
        run_block(X, 1'b0, r, lat);
        checks++;
        if (r !== Y || lat !== 4) begin
            failures++;
            $display("FAIL midrun_recover: got %h lat %0d want %h lat 4", r, lat, Y);
        end
    endtask

    initial begin
        test_reset;
        test_encrypt;
        test_decrypt;
        test_sweep;
        test_back_to_back;
        test_backpressure;
        test_reset_mid_run;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
